// File: rtl/alu8_pkg.sv
// alu8_pkg: shared types for the alu8 datapath ALU.
//   alu_op_e    - 3-bit opcode encoding (ADD..LSR = 0..7)
//   alu_flags_t - packed status flags {z, n, v, c}
package alu8_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_LSL = 3'd6,
    OP_LSR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } alu_flags_t;

endpackage

// File: rtl/alu8_addsub.sv
// alu8_addsub: shared WIDTH+1-bit adder for ADD/SUB.
//   a, b  - operands; b is inverted when sub=1 (a + ~b + cin)
//   cin   - carry in (for SUB, 1 = no borrow in)
//   sum   - WIDTH-bit result
//   cout  - carry out (for SUB, 1 = no borrow out)
//   ovf   - signed overflow
module alu8_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  // Overflow when both addends share a sign that the result does not.
  // With b inverted this is exactly the SUB rule (a, b signs differ).
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu8.sv
// alu8: parameterised integer ALU with live and registered status flags.
//   clk, rst      - flag register clock; async active-high reset clears it
//   A, B          - operands (B[SHW-1:0] is the shift amount for LSL/LSR)
//   OP            - opcode (alu_op_e)
//   C_in          - carry in, ADD/SUB only
//   EN            - enable; 0 forces Y to zero and shows held flags
//   update_flags  - 1: flags live and register loads; 0: flags held
//   Y             - combinational result
//   C_out,Z,N,V   - carry, zero, negative, signed-overflow flags
// Build option: define ALU_SHIFT_CARRY_EN to have LSL/LSR report the last
// bit shifted out on C_out (0 for a zero shift).
module alu8
  import alu8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             C_in,
  input  logic             EN,
  input  logic             update_flags,
  output logic [WIDTH-1:0] Y,
  output logic             C_out,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_e          op_e;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] as_sum;
  logic             as_c;
  logic             as_v;
  logic [WIDTH-1:0] res;
  alu_flags_t       calc;
  alu_flags_t       flags_q;
  alu_flags_t       flags_o;
  logic             live;

  assign op_e = alu_op_e'(OP);
  assign sh   = B[SHW-1:0];

  alu8_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (A),
    .b    (B),
    .sub  (op_e == OP_SUB),
    .cin  (C_in),
    .sum  (as_sum),
    .cout (as_c),
    .ovf  (as_v)
  );

`ifdef ALU_SHIFT_CARRY_EN
  // One extra bit on the far side of each shift catches the last bit out;
  // a zero shift leaves that bit at 0.
  logic [WIDTH:0] lsl_w;
  logic [WIDTH:0] lsr_w;
  assign lsl_w = {1'b0, A} << sh;
  assign lsr_w = {A, 1'b0} >> sh;
`endif

  always_comb begin
    res  = '0;
    calc = '0;
    case (op_e)
      OP_ADD, OP_SUB: begin
        res    = as_sum;
        calc.c = as_c;
        calc.v = as_v;
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
`ifdef ALU_SHIFT_CARRY_EN
      OP_LSL: begin
        res    = lsl_w[WIDTH-1:0];
        calc.c = lsl_w[WIDTH];
      end
      OP_LSR: begin
        res    = lsr_w[WIDTH:1];
        calc.c = lsr_w[0];
      end
`else
      OP_LSL: res = A << sh;
      OP_LSR: res = A >> sh;
`endif
      default: res = '0;
    endcase
    calc.z = (res == '0);
    calc.n = res[WIDTH-1];
  end

  assign live = EN && update_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       flags_q <= '0;
    else if (live) flags_q <= calc;
  end

  assign flags_o = live ? calc : flags_q;
  assign Y       = EN ? res : '0;
  assign Z       = flags_o.z;
  assign N       = flags_o.n;
  assign V       = flags_o.v;
  assign C_out   = flags_o.c;

endmodule

// File: tb/tb_alu8.sv
// tb_alu8: directed table, flag-hold sequence and randomized checks of alu8.
// Observed/expected values are packed as {Y[7:0], C, Z, N, V}.
module tb_alu8;

  logic       clk, rst;
  logic [7:0] A, B, Y;
  logic [2:0] OP;
  logic       C_in, EN, update_flags;
  logic       C_out, Z, N, V;

  int checks = 0;
  int errors = 0;

  alu8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .OP(OP), .C_in(C_in), .EN(EN),
    .update_flags(update_flags), .Y(Y), .C_out(C_out), .Z(Z), .N(N), .V(V)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

`ifdef ALU_SHIFT_CARRY_EN
  localparam bit SHC = 1'b1;
`else
  localparam bit SHC = 1'b0;
`endif

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Arithmetic reference: returns {y, c, z, n, v}
  function automatic logic [11:0] ref_calc(input logic [2:0] op, input int a,
                                           input int b, input int cin);
    int s, y, sh, nb, ss;
    bit c, v;
    c = 0; v = 0; y = 0;
    sh = b % 8;
    case (op)
      3'd0: begin
        s = a + b + cin; y = s % 256; c = (s >= 256);
        ss = sx(a) + sx(b) + cin; v = (ss > 127) || (ss < -128);
      end
      3'd1: begin
        nb = 255 - b;
        s = a + nb + cin; y = s % 256; c = (s >= 256);
        ss = sx(a) + sx(nb) + cin; v = (ss > 127) || (ss < -128);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = 255 - a;
      3'd6: begin
        y = (a * (2 ** sh)) % 256;
        if (SHC && sh != 0) c = ((a / (2 ** (8 - sh))) % 2) == 1;
      end
      default: begin
        y = a / (2 ** sh);
        if (SHC && sh != 0) c = ((a / (2 ** (sh - 1))) % 2) == 1;
      end
    endcase
    return {y[7:0], c, (y == 0), (y >= 128), v};
  endfunction

  // Flag register model: {c, z, n, v}
  logic [3:0] exp_reg;
  always @(posedge clk or posedge rst) begin
    logic [11:0] r;
    r = ref_calc(OP, int'(A), int'(B), int'(C_in));
    if (rst) exp_reg <= '0;
    else if (EN && update_flags) exp_reg <= r[3:0];
  end

  function automatic logic [11:0] expect_out();
    logic [11:0] r;
    logic [3:0]  held;
    r = ref_calc(OP, int'(A), int'(B), int'(C_in));
    held = rst ? 4'h0 : exp_reg;
    if (!EN) return {8'h00, held};
    if (!update_flags) return {r[11:4], held};
    return r;
  endfunction

  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = {Y, C_out, Z, N, V};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got Y=%h CZNV=%b, want Y=%h CZNV=%b",
               name, got[11:4], got[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic en, input logic uf);
    @(negedge clk);
    OP = op; A = a; B = b; C_in = cin; EN = en; update_flags = uf;
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic        cin;
    logic [11:0] exp;   // {Y, C, Z, N, V}
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{3'd0, 8'h7F, 8'h01, 1'b0, {8'h80, 4'b0011}};
    tbl[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 4'b1100}};
    tbl[2]  = '{3'd1, 8'h05, 8'h05, 1'b1, {8'h00, 4'b1100}};
    tbl[3]  = '{3'd1, 8'h80, 8'h01, 1'b0, {8'h7E, 4'b1001}};
    tbl[4]  = '{3'd2, 8'hF0, 8'h3C, 1'b1, {8'h30, 4'b0000}};
    tbl[5]  = '{3'd3, 8'hF0, 8'h3C, 1'b1, {8'hFC, 4'b0010}};
    tbl[6]  = '{3'd4, 8'hF0, 8'h3C, 1'b1, {8'hCC, 4'b0010}};
    tbl[7]  = '{3'd5, 8'hF0, 8'h3C, 1'b1, {8'h0F, 4'b0000}};
    tbl[8]  = '{3'd6, 8'h81, 8'h09, 1'b1, {8'h02, SHC, 3'b000}};
    tbl[9]  = '{3'd7, 8'h81, 8'h0F, 1'b1, {8'h01, 4'b0000}};
    tbl[10] = '{3'd6, 8'h81, 8'h08, 1'b1, {8'h81, 4'b0010}};  // sh=0
    tbl[11] = '{3'd7, 8'h81, 8'h01, 1'b0, {8'h40, SHC, 3'b000}};

    rst = 1; OP = 0; A = 8'h5A; B = 8'hA5; C_in = 1; EN = 0; update_flags = 1;
    #2;
    chk("reset_state", 12'h000);
    @(negedge clk); rst = 0;

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1, 1'b1);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Flag hold and async reset
    drive(3'd0, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
    chk("hold_load", {8'h00, 4'b1100});
    drive(3'd0, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("hold_flags", {8'h02, 4'b1100});
    drive(3'd0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    chk("en0_held", {8'h00, 4'b1100});
    drive(3'd0, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    rst = 1; #1;
    chk("async_rst", {8'h02, 4'b0000});
    @(posedge clk); #1;
    chk("rst_held", {8'h02, 4'b0000});
    @(negedge clk); rst = 0;
    #1;
    chk("rst_release", {8'h02, 4'b0000});

    // Randomized against the reference model
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 1000; k++) begin
        drive(3'(op), 8'($urandom), 8'($urandom), 1'($urandom),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
        chk($sformatf("rand_op%0d", op), expect_out());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
